// File: rtl/br_pkg.sv
// Shared encodings and types for the branch resolver and its prediction queue.
package br_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_BGEZ = 3'd6,
        BR_J    = 3'd7
    } br_type_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } pred_entry_t;

    localparam logic [31:0] PC_STEP         = 32'd4;
    localparam logic [31:0] DELAY_SLOT_STEP = 32'd8;

endpackage

// File: rtl/pred_queue.sv
// In-order FIFO of IF-stage predictions; whole-queue flush and sticky overflow on dropped push.
module pred_queue
    import br_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  pred_entry_t wr_entry,
    output pred_entry_t rd_entry,
    output logic        full,
    output logic        empty,
    output logic        overflow
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    pred_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             pop_ok;
    logic             push_ok;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign rd_entry = mem[rd_ptr];
    assign pop_ok   = pop & ~empty & ~flush;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push & ~flush & (~full | pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop_ok);
            if (push & ~push_ok) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/branch_resolver.sv
// ID-stage branch resolution against queued BTB predictions; drives BTB update, flush and redirect.
// Optional BRANCH_RESOLVER_STATS_EN adds branch and mispredict counters.
module branch_resolver
    import br_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        Valid_IN_IF,
    input  logic [31:0] Instr_PC_IN_IF,
    input  logic        Pred_Taken_IN_IF,
    input  logic [31:0] Pred_Target_IN_IF,
    input  logic        Valid_IN_ID,
    input  logic [31:0] Instr_PC_IN_ID,
    input  logic [2:0]  Br_Type_IN_ID,
    input  logic [31:0] Rs_IN_ID,
    input  logic [31:0] Rt_IN_ID,
    input  logic [25:0] Imm_IN_ID,
    output logic        is_Branch_OUT,
    output logic        is_Taken_OUT,
    output logic [31:0] Alt_PC_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic        FLUSH_OUT,
    output logic [31:0] Redirect_PC_OUT,
    output logic        Q_Overflow_OUT
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [31:0] Br_Count_OUT,
    output logic [31:0] Mispred_Count_OUT
`endif
);

    function automatic logic br_taken(input br_type_e typ,
                                      input logic signed [31:0] rs,
                                      input logic signed [31:0] rt);
        case (typ)
            BR_BEQ:  return rs == rt;
            BR_BNE:  return rs != rt;
            BR_BLEZ: return rs <= 32'sd0;
            BR_BGTZ: return rs >  32'sd0;
            BR_BLTZ: return rs[31];
            BR_BGEZ: return ~rs[31];
            BR_J:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] br_target(input br_type_e typ,
                                              input logic [31:0] pc4,
                                              input logic [25:0] imm);
        logic signed [31:0] off;
        off = {{14{imm[15]}}, imm[15:0], 2'b00};
        if (typ == BR_J) return {pc4[31:28], imm, 2'b00};
        return pc4 + off;
    endfunction

    br_type_e           br_type;
    logic signed [31:0] rs_s;
    logic signed [31:0] rt_s;
    logic [31:0]        pc4;
    logic [31:0]        target;
    logic               act_taken;
    pred_entry_t        head;
    pred_entry_t        wr_entry;
    logic               q_empty;
    logic               q_full;
    logic               head_match;
    logic               pred_taken;
    logic [31:0]        pred_target;
    logic               resolve;
    logic               flush_now;
    logic [31:0]        redirect;
    logic               push;
    logic               pop;

    assign br_type   = br_type_e'(Br_Type_IN_ID);
    assign rs_s      = Rs_IN_ID;
    assign rt_s      = Rt_IN_ID;
    assign pc4       = Instr_PC_IN_ID + PC_STEP;
    assign target    = br_target(br_type, pc4, Imm_IN_ID);
    assign act_taken = br_taken(br_type, rs_s, rt_s);

    // Without a matching head entry the fetch went down the fall-through path.
    assign head_match  = ~q_empty & (head.pc == Instr_PC_IN_ID);
    assign pred_taken  = head_match & head.taken;
    assign pred_target = head_match ? head.target : pc4;

    assign resolve   = Valid_IN_ID & ~STALL & (br_type != BR_NONE);
    assign flush_now = resolve & ((pred_taken ^ act_taken) |
                                  (pred_taken & act_taken & (pred_target != target)));
    assign redirect  = act_taken ? target : Instr_PC_IN_ID + DELAY_SLOT_STEP;

    assign pop      = Valid_IN_ID & ~STALL & head_match;
    assign push     = Valid_IN_IF & ~STALL & ~flush_now;
    assign wr_entry = '{pc: Instr_PC_IN_IF, taken: Pred_Taken_IN_IF, target: Pred_Target_IN_IF};

    pred_queue #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_queue (
        .clk      (CLK),
        .rst_n    (RESET),
        .push     (push),
        .pop      (pop),
        .flush    (flush_now),
        .wr_entry (wr_entry),
        .rd_entry (head),
        .full     (q_full),
        .empty    (q_empty),
        .overflow (Q_Overflow_OUT)
    );

    // ID -> output register stage
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            is_Branch_OUT   <= 1'b0;
            FLUSH_OUT       <= 1'b0;
            is_Taken_OUT    <= 1'b0;
            Alt_PC_OUT      <= '0;
            Instr_PC_OUT    <= '0;
            Redirect_PC_OUT <= '0;
        end else begin
            is_Branch_OUT <= resolve;
            FLUSH_OUT     <= flush_now;
            if (resolve) begin
                is_Taken_OUT <= act_taken;
                Alt_PC_OUT   <= target;
                Instr_PC_OUT <= Instr_PC_IN_ID;
            end
            if (flush_now) Redirect_PC_OUT <= redirect;
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Br_Count_OUT      <= '0;
            Mispred_Count_OUT <= '0;
        end else begin
            Br_Count_OUT      <= Br_Count_OUT + 32'(is_Branch_OUT);
            Mispred_Count_OUT <= Mispred_Count_OUT + 32'(FLUSH_OUT);
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed-vector bench for branch_resolver with hand-computed expectations.
module tb_branch_resolver;
    import br_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        STALL;
    logic        Valid_IN_IF;
    logic [31:0] Instr_PC_IN_IF;
    logic        Pred_Taken_IN_IF;
    logic [31:0] Pred_Target_IN_IF;
    logic        Valid_IN_ID;
    logic [31:0] Instr_PC_IN_ID;
    logic [2:0]  Br_Type_IN_ID;
    logic [31:0] Rs_IN_ID;
    logic [31:0] Rt_IN_ID;
    logic [25:0] Imm_IN_ID;
    logic        is_Branch_OUT;
    logic        is_Taken_OUT;
    logic [31:0] Alt_PC_OUT;
    logic [31:0] Instr_PC_OUT;
    logic        FLUSH_OUT;
    logic [31:0] Redirect_PC_OUT;
    logic        Q_Overflow_OUT;
`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] Br_Count_OUT;
    logic [31:0] Mispred_Count_OUT;
`endif

    int n_vec = 0;
    int n_err = 0;

    branch_resolver #(.DEPTH(4), .PTR_W(2)) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .STALL             (STALL),
        .Valid_IN_IF       (Valid_IN_IF),
        .Instr_PC_IN_IF    (Instr_PC_IN_IF),
        .Pred_Taken_IN_IF  (Pred_Taken_IN_IF),
        .Pred_Target_IN_IF (Pred_Target_IN_IF),
        .Valid_IN_ID       (Valid_IN_ID),
        .Instr_PC_IN_ID    (Instr_PC_IN_ID),
        .Br_Type_IN_ID     (Br_Type_IN_ID),
        .Rs_IN_ID          (Rs_IN_ID),
        .Rt_IN_ID          (Rt_IN_ID),
        .Imm_IN_ID         (Imm_IN_ID),
        .is_Branch_OUT     (is_Branch_OUT),
        .is_Taken_OUT      (is_Taken_OUT),
        .Alt_PC_OUT        (Alt_PC_OUT),
        .Instr_PC_OUT      (Instr_PC_OUT),
        .FLUSH_OUT         (FLUSH_OUT),
        .Redirect_PC_OUT   (Redirect_PC_OUT),
        .Q_Overflow_OUT    (Q_Overflow_OUT)
`ifdef BRANCH_RESOLVER_STATS_EN
        ,
        .Br_Count_OUT      (Br_Count_OUT),
        .Mispred_Count_OUT (Mispred_Count_OUT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        STALL             = 1'b0;
        Valid_IN_IF       = 1'b0;
        Instr_PC_IN_IF    = '0;
        Pred_Taken_IN_IF  = 1'b0;
        Pred_Target_IN_IF = '0;
        Valid_IN_ID       = 1'b0;
        Instr_PC_IN_ID    = '0;
        Br_Type_IN_ID     = BR_NONE;
        Rs_IN_ID          = '0;
        Rt_IN_ID          = '0;
        Imm_IN_ID         = '0;
    endtask

    task automatic set_if(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        Valid_IN_IF       = 1'b1;
        Instr_PC_IN_IF    = pc;
        Pred_Taken_IN_IF  = tk;
        Pred_Target_IN_IF = tgt;
    endtask

    task automatic set_id(input logic [31:0] pc, input br_type_e typ, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [25:0] imm);
        Valid_IN_ID    = 1'b1;
        Instr_PC_IN_ID = pc;
        Br_Type_IN_ID  = typ;
        Rs_IN_ID       = rs;
        Rt_IN_ID       = rt;
        Imm_IN_ID      = imm;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_br"},    32'(is_Branch_OUT),  32'd0);
        check({tag, "_tk"},    32'(is_Taken_OUT),   32'd0);
        check({tag, "_alt"},   Alt_PC_OUT,          32'd0);
        check({tag, "_pc"},    Instr_PC_OUT,        32'd0);
        check({tag, "_flush"}, 32'(FLUSH_OUT),      32'd0);
        check({tag, "_redir"}, Redirect_PC_OUT,     32'd0);
        check({tag, "_ovf"},   32'(Q_Overflow_OUT), 32'd0);
`ifdef BRANCH_RESOLVER_STATS_EN
        check({tag, "_brcnt"}, Br_Count_OUT,        32'd0);
        check({tag, "_mpcnt"}, Mispred_Count_OUT,   32'd0);
`endif
    endtask

    initial begin
        RESET = 1'b0;
        idle();
        tick();
        tick();
        check_zero("rst");
        RESET = 1'b1;
        tick();

        // 1: predicted NT, BEQ taken -> flush to target
        set_if(32'h100, 1'b0, 32'h0);
        tick();
        idle();
        set_id(32'h100, BR_BEQ, 32'd5, 32'd5, 26'h0004);
        tick();
        check("t1_br",    32'(is_Branch_OUT), 32'd1);
        check("t1_tk",    32'(is_Taken_OUT),  32'd1);
        check("t1_alt",   Alt_PC_OUT,         32'h114);
        check("t1_pc",    Instr_PC_OUT,       32'h100);
        check("t1_flush", 32'(FLUSH_OUT),     32'd1);
        check("t1_redir", Redirect_PC_OUT,    32'h114);
        idle();
        tick();
        check("t1_pulse_flush", 32'(FLUSH_OUT),     32'd0);
        check("t1_pulse_br",    32'(is_Branch_OUT), 32'd0);

        // 2: predicted T, BNE not taken -> redirect past delay slot
        set_if(32'h200, 1'b1, 32'h240);
        tick();
        idle();
        set_id(32'h200, BR_BNE, 32'd7, 32'd7, 26'h0);
        tick();
        check("t2_flush", 32'(FLUSH_OUT),  32'd1);
        check("t2_redir", Redirect_PC_OUT, 32'h208);
        check("t2_tk",    32'(is_Taken_OUT), 32'd0);
        check("t2_alt",   Alt_PC_OUT,      32'h204);

        // 3: BGTZ taken, target correct then wrong
        set_if(32'h300, 1'b1, 32'h320);
        tick();
        idle();
        set_id(32'h300, BR_BGTZ, 32'd1, 32'd0, 26'h0007);
        tick();
        check("t3a_br",    32'(is_Branch_OUT), 32'd1);
        check("t3a_flush", 32'(FLUSH_OUT),     32'd0);
        check("t3a_alt",   Alt_PC_OUT,         32'h320);
        idle();
        set_if(32'h300, 1'b1, 32'h324);
        tick();
        idle();
        set_id(32'h300, BR_BGTZ, 32'd1, 32'd0, 26'h0007);
        tick();
        check("t3b_flush", 32'(FLUSH_OUT), 32'd1);
        check("t3b_redir", Redirect_PC_OUT, 32'h320);

        // signed compare and negative offset, no queue entry
        idle();
        set_id(32'h340, BR_BLEZ, 32'hFFFF_FFFF, 32'd0, 26'h0FFFF);
        tick();
        check("blez_tk",    32'(is_Taken_OUT), 32'd1);
        check("blez_alt",   Alt_PC_OUT,        32'h340);
        check("blez_flush", 32'(FLUSH_OUT),    32'd1);
        check("blez_redir", Redirect_PC_OUT,   32'h340);
        idle();
        set_id(32'h380, BR_BGEZ, 32'h8000_0000, 32'd0, 26'h0001);
        tick();
        check("bgez_tk",    32'(is_Taken_OUT), 32'd0);
        check("bgez_flush", 32'(FLUSH_OUT),    32'd0);
        check("bgez_br",    32'(is_Branch_OUT), 32'd1);

        // 4: fill, overflow, push+pop while full, then drain in order
        idle();
        for (int i = 0; i < 4; i++) begin
            set_if(32'h1000 + 32'(i) * 32'h10, 1'b1, 32'h400);
            tick();
        end
        check("t4_no_ovf", 32'(Q_Overflow_OUT), 32'd0);
        set_if(32'h1040, 1'b1, 32'h400);
        tick();
        check("t4_ovf", 32'(Q_Overflow_OUT), 32'd1);
        set_if(32'h1050, 1'b1, 32'h400);
        set_id(32'h1000, BR_J, 32'd0, 32'd0, 26'h100);
        tick();
        check("t4_pp_flush", 32'(FLUSH_OUT), 32'd0);
        check("t4_pp_alt",   Alt_PC_OUT,     32'h400);
        idle();
        for (int i = 0; i < 4; i++) begin
            set_id((i == 3) ? 32'h1050 : 32'h1010 + 32'(i) * 32'h10, BR_J, 32'd0, 32'd0, 26'h100);
            tick();
            check($sformatf("t4_drain%0d_flush", i), 32'(FLUSH_OUT), 32'd0);
        end
        set_id(32'h1040, BR_J, 32'd0, 32'd0, 26'h100);
        tick();
        check("t4_dropped_flush", 32'(FLUSH_OUT), 32'd1);
        check("t4_ovf_sticky",    32'(Q_Overflow_OUT), 32'd1);

        // 5: IF push in the flush cycle is discarded
        idle();
        set_if(32'h400, 1'b0, 32'h0);
        tick();
        idle();
        set_id(32'h400, BR_J, 32'd0, 32'd0, 26'h100);
        set_if(32'h404, 1'b1, 32'h400);
        tick();
        check("t5_flush", 32'(FLUSH_OUT), 32'd1);
        check("t5_redir", Redirect_PC_OUT, 32'h400);
        idle();
        set_id(32'h404, BR_J, 32'd0, 32'd0, 26'h100);
        tick();
        check("t5_nomatch_flush", 32'(FLUSH_OUT), 32'd1);

        // 6: stall hold, then async reset mid-stream
        idle();
        for (int i = 0; i < 3; i++) begin
            set_if(32'h600 + 32'(i) * 32'h10, 1'b1, 32'h400);
            tick();
        end
        idle();
        set_id(32'h600, BR_J, 32'd0, 32'd0, 26'h100);
        tick();
        check("t6_br",    32'(is_Branch_OUT), 32'd1);
        check("t6_flush", 32'(FLUSH_OUT),     32'd0);
        STALL = 1'b1;
        set_id(32'h610, BR_BEQ, 32'd1, 32'd2, 26'h3);
        tick();
        check("t6_stall_br",  32'(is_Branch_OUT), 32'd0);
        check("t6_stall_alt", Alt_PC_OUT,         32'h400);
        check("t6_stall_pc",  Instr_PC_OUT,       32'h600);
        check("t6_stall_tk",  32'(is_Taken_OUT),  32'd1);
        idle();
        #2;
        RESET = 1'b0;
        #1;
        check_zero("t6_rst");
        tick();
        RESET = 1'b1;
        set_if(32'h500, 1'b1, 32'h504);
        tick();
        idle();
        set_id(32'h500, BR_BEQ, 32'd3, 32'd3, 26'h0);
        tick();
        check("t6_post_br",    32'(is_Branch_OUT), 32'd1);
        check("t6_post_flush", 32'(FLUSH_OUT),     32'd0);
        check("t6_post_alt",   Alt_PC_OUT,         32'h504);
        check("t6_post_pc",    Instr_PC_OUT,       32'h500);
`ifdef BRANCH_RESOLVER_STATS_EN
        idle();
        tick();
        check("t6_brcnt", Br_Count_OUT,      32'd1);
        check("t6_mpcnt", Mispred_Count_OUT, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
